m_memarb: RTL and testbench

Single-port memory arbiter/sequencer for the pipelined processor core. It shares one synchronous 4K-word RAM (1-cycle read latency, read-before-write) between three requesters: the instruction fetch port (I), the data access port (D) and a host loader port (L) used to download programs. It produces per-port grants and stall signals, and routes read data back with a registered valid tag. It also counts I/D conflict cycles for performance measurement.

---
 rtl/m_memarb.sv | 138 +++++++++++++
 tb/tb_m_memarb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/m_memarb.sv
// rtl/m_memarb.sv - single-port RAM arbiter/sequencer for I fetch, D access and host loader
//
// Ports:
//   w_clk, w_rst                     clock, synchronous active-high reset
//   w_{l,d,i}_req / _addr            per-port request and word address
//   w_{l,d}_we / _din                write enable and write data (I is read-only)
//   w_{l,d,i}_gnt                    combinational same-cycle grants
//   w_d_stall, w_i_stall             request pending but not granted
//   r_{l,d,i}_rvalid                 read data valid for that port (1 cycle after grant)
//   w_rdata                          shared read data, straight from the RAM
//   w_ram_addr/_we/_din, w_ram_dout  RAM drive and RAM registered output
//   r_busy                           high while loading or draining
//   r_conflicts                      saturating count of RUN cycles with I and D both requesting
module m_memarb #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_l_req,
    input  logic              w_d_req,
    input  logic              w_i_req,
    input  logic              w_l_we,
    input  logic              w_d_we,
    input  logic [ADDR_W-1:0] w_l_addr,
    input  logic [ADDR_W-1:0] w_d_addr,
    input  logic [ADDR_W-1:0] w_i_addr,
    input  logic [DATA_W-1:0] w_l_din,
    input  logic [DATA_W-1:0] w_d_din,
    output logic              w_l_gnt,
    output logic              w_d_gnt,
    output logic              w_i_gnt,
    output logic              w_d_stall,
    output logic              w_i_stall,
    output logic              r_l_rvalid,
    output logic              r_d_rvalid,
    output logic              r_i_rvalid,
    output logic [DATA_W-1:0] w_rdata,
    output logic [ADDR_W-1:0] w_ram_addr,
    output logic              w_ram_we,
    output logic [DATA_W-1:0] w_ram_din,
    input  logic [DATA_W-1:0] w_ram_dout,
    output logic              r_busy,
    output logic [15:0]       r_conflicts
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t     r_state;
    logic [2:0] r_starve;
    logic       w_run_open;
    logic       w_starved;

    // A loader request seen in RUN takes the cycle itself (no grant) so the
    // switch into LOAD never overlaps a core access.
    assign w_run_open = ~w_rst & (r_state == RUN) & ~w_l_req;
    assign w_starved  = (r_starve == STARVE_LIM);

    assign w_l_gnt = ~w_rst & (r_state == LOAD) & w_l_req;
    assign w_i_gnt = w_run_open & w_i_req & (~w_d_req | w_starved);
    assign w_d_gnt = w_run_open & w_d_req & ~w_i_gnt;

    assign w_d_stall = w_d_req & ~w_d_gnt;
    assign w_i_stall = w_i_req & ~w_i_gnt;
    assign w_rdata   = w_ram_dout;

    // Idle cycles park the RAM on the fetch address with writes disabled.
    always_comb begin
        w_ram_addr = w_i_addr;
        w_ram_we   = 1'b0;
        w_ram_din  = w_d_din;
        if (w_l_gnt) begin
            w_ram_addr = w_l_addr;
            w_ram_we   = w_l_we;
            w_ram_din  = w_l_din;
        end else if (w_d_gnt) begin
            w_ram_addr = w_d_addr;
            w_ram_we   = w_d_we;
            w_ram_din  = w_d_din;
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state     <= RUN;
            r_busy      <= 1'b0;
            r_starve    <= 3'd0;
            r_conflicts <= 16'd0;
            r_l_rvalid  <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_i_rvalid  <= 1'b0;
        end else begin
            r_l_rvalid <= w_l_gnt & ~w_l_we;
            r_d_rvalid <= w_d_gnt & ~w_d_we;
            r_i_rvalid <= w_i_gnt;

            case (r_state)
                RUN: begin
                    if (w_l_req) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (!w_l_req) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_state <= RUN;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= RUN;
                    r_busy  <= 1'b0;
                end
            endcase

            if ((r_state != RUN) || w_i_gnt || !w_i_req) begin
                r_starve <= 3'd0;
            end else if (r_starve != 3'd7) begin
                r_starve <= r_starve + 3'd1;
            end

            if ((r_state == RUN) && w_i_req && w_d_req && (r_conflicts != 16'hffff)) begin
                r_conflicts <= r_conflicts + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_m_memarb.sv
// tb/tb_m_memarb.sv - scoreboard bench for m_memarb with a behavioural RAM
module tb_m_memarb;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          l_req, d_req, i_req, l_we, d_we;
    logic [AW-1:0] l_addr, d_addr, i_addr;
    logic [DW-1:0] l_din, d_din;
    logic          l_gnt, d_gnt, i_gnt, d_stall, i_stall;
    logic          l_rvalid, d_rvalid, i_rvalid;
    logic [DW-1:0] rdata, ram_din, ram_dout;
    logic [AW-1:0] ram_addr;
    logic          ram_we, busy;
    logic [15:0]   conflicts;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;
    int exp_port [$];
    logic [DW-1:0] exp_data [$];

    m_memarb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
        .w_clk(clk), .w_rst(rst),
        .w_l_req(l_req), .w_d_req(d_req), .w_i_req(i_req),
        .w_l_we(l_we), .w_d_we(d_we),
        .w_l_addr(l_addr), .w_d_addr(d_addr), .w_i_addr(i_addr),
        .w_l_din(l_din), .w_d_din(d_din),
        .w_l_gnt(l_gnt), .w_d_gnt(d_gnt), .w_i_gnt(i_gnt),
        .w_d_stall(d_stall), .w_i_stall(i_stall),
        .r_l_rvalid(l_rvalid), .r_d_rvalid(d_rvalid), .r_i_rvalid(i_rvalid),
        .w_rdata(rdata),
        .w_ram_addr(ram_addr), .w_ram_we(ram_we), .w_ram_din(ram_din),
        .w_ram_dout(ram_dout),
        .r_busy(busy), .r_conflicts(conflicts)
    );

    always #5 clk = ~clk;

    // Synchronous RAM, 1-cycle latency, read-before-write.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_read(input int port, input logic [DW-1:0] data);
        exp_port.push_back(port);
        exp_data.push_back(data);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: port code 0=L, 1=D, 2=I.
    always @(negedge clk) begin
        int n;
        int port;
        n = int'(l_rvalid) + int'(d_rvalid) + int'(i_rvalid);
        port = l_rvalid ? 0 : (d_rvalid ? 1 : 2);
        if (n > 1) begin
            checks++;
            errors++;
            $display("FAIL rvalid_onehot: got %0d valids expected 1", n);
        end else if (n == 1) begin
            if (exp_port.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got port %0d data %0h expected none", port, rdata);
            end else begin
                chk("rvalid_port", DW'(port), DW'(exp_port.pop_front()));
                chk("rdata", rdata, exp_data.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
        mem[0] = 32'h20; mem[1] = 32'h11; mem[2] = 32'h22; mem[3] = 32'h33;
        rst = 1'b1;
        l_req = 1'b1; d_req = 1'b1; i_req = 1'b1;
        l_we = 1'b1; d_we = 1'b1;
        l_addr = '0; d_addr = '0; i_addr = '0;
        l_din = '0; d_din = '0;

        // Reset with everything requesting.
        @(negedge clk);
        chk("rst_l_gnt", DW'(l_gnt), 0);
        chk("rst_d_gnt", DW'(d_gnt), 0);
        chk("rst_i_gnt", DW'(i_gnt), 0);
        chk("rst_ram_we", DW'(ram_we), 0);
        next_cycle();
        @(negedge clk);
        chk("rst_busy", DW'(busy), 0);
        chk("rst_conflicts", DW'(conflicts), 0);
        chk("rst_rvalid", DW'({l_rvalid, d_rvalid, i_rvalid}), 0);

        // First cycle out of reset: D wins over I.
        next_cycle();
        rst = 1'b0; l_req = 1'b0; l_we = 1'b0; d_we = 1'b0; d_addr = 3; i_addr = 0;
        @(negedge clk);
        chk("first_d_gnt", DW'(d_gnt), 1);
        chk("first_i_gnt", DW'(i_gnt), 0);
        chk("first_i_stall", DW'(i_stall), 1);
        chk("first_d_stall", DW'(d_stall), 0);
        expect_read(1, 32'h33);
        next_cycle();
        d_req = 1'b0; i_req = 1'b0;
        next_cycle();

        // I-only reads, one per cycle.
        for (int k = 0; k < 3; k++) begin
            i_req = 1'b1; i_addr = AW'(k);
            @(negedge clk);
            chk("ionly_i_gnt", DW'(i_gnt), 1);
            expect_read(2, (k == 0) ? 32'h20 : ((k == 1) ? 32'h11 : 32'h22));
            next_cycle();
        end
        i_req = 1'b0;
        next_cycle();

        // Continuous I and D: D,D,D,D,I repeating.
        d_req = 1'b1; i_req = 1'b1; d_addr = 3; i_addr = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("starve_i_gnt", DW'(i_gnt), DW'(c % 5 == 4));
            chk("starve_d_gnt", DW'(d_gnt), DW'(c % 5 != 4));
            if (c % 5 == 4) expect_read(2, 32'h20);
            else expect_read(1, 32'h33);
            next_cycle();
        end
        d_req = 1'b0; i_req = 1'b0;
        @(negedge clk);
        chk("conflicts_11", DW'(conflicts), 11);
        next_cycle();

        // D write then read-back; write gives no rvalid.
        d_req = 1'b1; d_we = 1'b1; d_addr = 5; d_din = 32'hdeadbeef;
        @(negedge clk);
        chk("dwr_gnt", DW'(d_gnt), 1);
        chk("dwr_ram_we", DW'(ram_we), 1);
        chk("dwr_ram_addr", DW'(ram_addr), 5);
        next_cycle();
        d_we = 1'b0;
        @(negedge clk);
        chk("drd_gnt", DW'(d_gnt), 1);
        chk("drd_ram_we", DW'(ram_we), 0);
        expect_read(1, 32'hdeadbeef);
        next_cycle();
        d_req = 1'b0;

        // Loader burst while I keeps requesting.
        l_req = 1'b1; l_we = 1'b1; l_addr = 10; l_din = 32'ha0; i_req = 1'b1; i_addr = 7;
        @(negedge clk);
        chk("lentry_l_gnt", DW'(l_gnt), 0);
        chk("lentry_i_gnt", DW'(i_gnt), 0);
        chk("lentry_i_stall", DW'(i_stall), 1);
        chk("lentry_ram_we", DW'(ram_we), 0);
        chk("lentry_ram_addr", DW'(ram_addr), 7);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            l_addr = AW'(10 + k); l_din = 32'ha0 + DW'(k);
            @(negedge clk);
            chk("load_l_gnt", DW'(l_gnt), 1);
            chk("load_i_gnt", DW'(i_gnt), 0);
            chk("load_busy", DW'(busy), 1);
            chk("load_ram_we", DW'(ram_we), 1);
            next_cycle();
        end
        l_req = 1'b0; l_we = 1'b0;
        @(negedge clk);
        chk("lexit_i_gnt", DW'(i_gnt), 0);
        chk("lexit_busy", DW'(busy), 1);
        next_cycle();
        @(negedge clk);
        chk("drain_i_gnt", DW'(i_gnt), 0);
        chk("drain_busy", DW'(busy), 1);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            i_addr = AW'(10 + k);
            @(negedge clk);
            chk("postload_i_gnt", DW'(i_gnt), 1);
            chk("postload_busy", DW'(busy), 0);
            expect_read(2, 32'ha0 + DW'(k));
            next_cycle();
        end
        i_req = 1'b0;
        next_cycle();

        // Reset right after a D read grant.
        d_req = 1'b1; i_req = 1'b1; d_addr = 3; d_we = 1'b0;
        @(negedge clk);
        chk("prerst_d_gnt", DW'(d_gnt), 1);
        expect_read(1, 32'h33);
        next_cycle();
        rst = 1'b1; l_req = 1'b1; l_we = 1'b1;
        @(negedge clk);
        chk("midrst_gnts", DW'({l_gnt, d_gnt, i_gnt}), 0);
        chk("midrst_ram_we", DW'(ram_we), 0);
        next_cycle();
        rst = 1'b0; l_req = 1'b0; l_we = 1'b0; d_req = 1'b0; i_req = 1'b0;
        @(negedge clk);
        chk("postrst_d_rvalid", DW'(d_rvalid), 0);
        chk("postrst_conflicts", DW'(conflicts), 0);
        chk("postrst_busy", DW'(busy), 0);
        next_cycle();
        d_req = 1'b1;
        @(negedge clk);
        chk("postrst_d_gnt", DW'(d_gnt), 1);
        expect_read(1, 32'h33);
        next_cycle();
        d_req = 1'b0;
        repeat (3) next_cycle();
        chk("scoreboard_empty", DW'(exp_port.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
